// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and helpers for the digit-serial BCD adder.
// Pure declarations; no logic of its own.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_CORR    = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add with +6 decimal correction.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Carry-in added before correction, so 9+9+1 gives digit 9 with carry 1.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] t;
    logic [4:0] t_corr;

    always_comb begin
        t      = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        t_corr = t + {1'b0, BCD_CORR};
        if (t > {1'b0, BCD_MAX}) begin
            s  = t_corr[3:0];
            co = 1'b1;
        end else begin
            s  = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first; BCD_SUB_EN adds ten's-complement A-B.
// Latency: DIGITS cycles after accept (1 cycle when an operand holds a non-BCD digit).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no operand queueing.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                         cin,
    input  logic                         sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                         cout,
    output logic                         err_a,
    output logic                         err_b
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [3:0] b_op;
    logic [3:0] s_dig;
    logic       co_dig;
    logic       bad_a;
    logic       bad_b;
    logic       carry_load;

`ifdef BCD_SUB_EN
    logic sub_r;

    // Subtract is A + nines(B) + 1; the +1 replaces cin.
    assign carry_load = sub ? 1'b1 : cin;
    assign b_op       = sub_r ? nines_comp(b_dig) : b_dig;
`else
    logic unused_sub;

    assign unused_sub = sub;
    assign carry_load = cin;
    assign b_op       = b_dig;
`endif

    assign a_dig = a_r[BCD_DIGIT_W*idx +: BCD_DIGIT_W];
    assign b_dig = b_r[BCD_DIGIT_W*idx +: BCD_DIGIT_W];

    // Validate the incoming operands so the flags are ready at the accept edge.
    always_comb begin
        bad_a = 1'b0;
        bad_b = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX) bad_a = 1'b1;
            if (b[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX) bad_b = 1'b1;
        end
    end

    bcd_digit_add u_digit_add (
        .a  (a_dig),
        .b  (b_op),
        .ci (carry),
        .s  (s_dig),
        .co (co_dig)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
`ifdef BCD_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= carry_load;
                        sum      <= '0;
                        cout     <= 1'b0;
                        err_a    <= bad_a;
                        err_b    <= bad_b;
                        idx      <= '0;
                        in_ready <= 1'b0;
`ifdef BCD_SUB_EN
                        sub_r    <= sub;
`endif
                        if (bad_a || bad_b) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    sum[BCD_DIGIT_W*idx +: BCD_DIGIT_W] <= s_dig;
                    carry <= co_dig;
                    if (idx == LAST_IDX) begin
                        cout      <= co_dig;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): vector table, corner sequences, random ops
// against an integer-arithmetic reference model. Sub-mode expectations follow BCD_SUB_EN.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err_a;
    logic         err_b;

    int n_vec  = 0;
    int n_fail = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err_a     (err_a),
        .err_b     (err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ea;
        logic         exp_eb;
        int           exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int from_bcd(input logic [W-1:0] x);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Decimal reference: plain integer sum / ten's-complement difference modulo 10^DIGITS.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic su,
                                  output logic [W-1:0] s, output logic co,
                                  output logic ea, output logic eb, output int lat);
        int modv = 1;
        int tot;
        ea = 1'b0;
        eb = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            modv = modv * 10;
            if (x[4*i +: 4] > 4'd9) ea = 1'b1;
            if (y[4*i +: 4] > 4'd9) eb = 1'b1;
        end
        if (ea || eb) begin
            s   = '0;
            co  = 1'b0;
            lat = 1;
            return;
        end
        if (su && SUB_ON) tot = from_bcd(x) - from_bcd(y) + modv;
        else              tot = from_bcd(x) + from_bcd(y) + int'(ci);
        co  = (tot >= modv);
        s   = to_bcd(tot % modv);
        lat = DIGITS + 1;
    endfunction

    // lat counts clock edges from the accept edge up to the first one after which out_valid is seen.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ci, input logic su, input int stall,
                          output logic [W-1:0] rs, output logic rc,
                          output logic rea, output logic reb, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ia; b = ib; cin = ci; sub = su; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        rs = sum; rc = cout; rea = err_a; reb = err_b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic apply_check(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic ci, input logic su, input int stall,
                               input logic [W-1:0] es, input logic ec,
                               input logic eea, input logic eeb, input int elat);
        logic [W-1:0] rs;
        logic         rc, rea, reb;
        int           lat;
        run_op(ia, ib, ci, su, stall, rs, rc, rea, reb, lat);
        check({name, " sum"},     32'(rs),  32'(es));
        check({name, " cout"},    32'(rc),  32'(ec));
        check({name, " err_a"},   32'(rea), 32'(eea));
        check({name, " err_b"},   32'(reb), 32'(eeb));
        check({name, " latency"}, 32'(lat), 32'(elat));
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rci, rsu, ec, eea, eeb;
        int           elat;
        bit           ov_ok, sum_ok, rdy_ok;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h00A1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{16'h0001, 16'h1F00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h5555, 16'h4445, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5});
`ifdef BCD_SUB_EN
        vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h4321, 16'h4321, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 5});
`else
        vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 5});
`endif

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum",       32'(sum),       32'd0);
        check("reset cout",      32'(cout),      32'd0);
        check("reset err",       32'({err_a, err_b}), 32'd0);

        foreach (vecs[i])
            apply_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0,
                        vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ea, vecs[i].exp_eb,
                        vecs[i].exp_lat);

        // Backpressure: result held for 10 cycles, competing in_valid ignored.
        a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("bp first out_valid", 32'(out_valid), 32'd1);
        ov_ok = 1'b1; sum_ok = 1'b1; rdy_ok = 1'b1;
        a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1) ov_ok = 1'b0;
            if (sum !== 16'h6912) sum_ok = 1'b0;
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
        end
        check("bp out_valid held", 32'(ov_ok),  32'd1);
        check("bp sum held",       32'(sum_ok), 32'd1);
        check("bp in_ready low",   32'(rdy_ok), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready",  32'(in_ready),  32'd1);
        check("bp sum kept",          32'(sum),       32'h6912);
        repeat (6) begin @(posedge clk); #1; end
        check("bp no queued op", 32'(out_valid), 32'd0);

        // Reset during the second RUN cycle.
        a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst run in_ready",  32'(in_ready),  32'd1);
        check("rst run out_valid", 32'(out_valid), 32'd0);
        check("rst run sum",       32'(sum),       32'd0);
        apply_check("after rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0, 5);

        // Reset while holding a result in DONE.
        a = 16'h0007; b = 16'h0008; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst done out_valid", 32'(out_valid), 32'd0);
        check("rst done sum",       32'(sum),       32'd0);

        // Random operands with occasional non-BCD nibbles and random consumer stalls.
        for (int n = 0; n < 60; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            rci = 1'($urandom_range(0, 1));
            rsu = 1'($urandom_range(0, 1));
            model(ra, rb, rci, rsu, es, ec, eea, eeb, elat);
            apply_check($sformatf("rand%0d %h%s%h", n, ra, rsu ? "-" : "+", rb), ra, rb, rci, rsu,
                        $urandom_range(0, 3), es, ec, eea, eeb, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
